lab_ms_sv4_issuer: RTL and testbench

//  Initiator side of the ALU instruction interface. Accepts a 3-byte command stream (header, op_a, op_b) over

---
 rtl/lab_MS_SV4_pack.sv | 64 ++++++
 rtl/lab_ms_sv4_issuer.sv | 118 +++++++++++
 tb/tb_lab_ms_sv4_issuer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab_MS_SV4_pack.sv
// Shared types for the ALU instruction issuer: opcodes, instruction word,
// data widths, issuer FSM states and the response-selection helper.
package lab_MS_SV4_pack;

  typedef logic [7:0]  data_x;
  typedef logic [15:0] data_y;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    VAR = 3'd4
  } opc_t;

  typedef struct packed {
    opc_t  opc;
    data_x op_a;
    data_x op_b;
  } INST_t;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    EXEC  = 3'd3,
    RESP  = 3'd4
  } st_t;

  localparam data_y ISSUER_ERR_VAL = 16'hFFFF;

  typedef struct packed {
    logic  err;
    data_y data;
  } resp_t;

  // Opcodes 5..7 and divide-by-zero never pass the ALU result through.
  function automatic resp_t issue_result(input INST_t inst, input data_y alu);
    resp_t r;
    r.err  = 1'b0;
    r.data = alu;
    case (inst.opc)
      ADD, SUB, MUL, VAR: begin
        r.err  = 1'b0;
        r.data = alu;
      end
      DIV: begin
        if (inst.op_b == 8'h00) begin
          r.err  = 1'b1;
          r.data = ISSUER_ERR_VAL;
        end else begin
          r.err  = 1'b0;
          r.data = alu;
        end
      end
      default: begin
        r.err  = 1'b1;
        r.data = 16'h0000;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lab_ms_sv4_issuer.sv
// ALU instruction issuer: collects header/op_a/op_b bytes, presents INST to the
// combinational ALU, registers the result and returns it over valid/ready.
module lab_ms_sv4_issuer
  import lab_MS_SV4_pack::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output INST_t            INST,
  input  data_y            ALU_out,
  output data_y            m_data,
  output logic             m_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] op_cnt
);

  st_t              state_r, state_nxt_s;
  INST_t            inst_r, inst_nxt_s;
  data_y            m_data_r, m_data_nxt_s;
  logic             m_err_r, m_err_nxt_s;
  logic             m_valid_r, m_valid_nxt_s;
  logic [CNT_W-1:0] op_cnt_r, op_cnt_nxt_s;
  logic             s_ready_s;
  logic             byte_xfer_s;
  resp_t            exec_resp_s;

  // Held low through reset so no byte is taken before the FSM is live.
  assign s_ready_s   = rst_n && ((state_r == HDR) || (state_r == GET_A) || (state_r == GET_B));
  assign byte_xfer_s = s_valid && s_ready_s;
  assign exec_resp_s = issue_result(inst_r, ALU_out);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= HDR;
      inst_r    <= '0;
      m_data_r  <= 16'h0000;
      m_err_r   <= 1'b0;
      m_valid_r <= 1'b0;
      op_cnt_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      inst_r    <= inst_nxt_s;
      m_data_r  <= m_data_nxt_s;
      m_err_r   <= m_err_nxt_s;
      m_valid_r <= m_valid_nxt_s;
      op_cnt_r  <= op_cnt_nxt_s;
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    state_nxt_s   = state_r;
    inst_nxt_s    = inst_r;
    m_data_nxt_s  = m_data_r;
    m_err_nxt_s   = m_err_r;
    m_valid_nxt_s = m_valid_r;
    op_cnt_nxt_s  = op_cnt_r;
    case (state_r)
      HDR: begin
        if (byte_xfer_s) begin
          inst_nxt_s.opc = opc_t'(s_data[2:0]);
          state_nxt_s    = GET_A;
        end else begin
          state_nxt_s = HDR;
        end
      end
      GET_A: begin
        if (byte_xfer_s) begin
          inst_nxt_s.op_a = s_data;
          state_nxt_s     = GET_B;
        end else begin
          state_nxt_s = GET_A;
        end
      end
      GET_B: begin
        if (byte_xfer_s) begin
          inst_nxt_s.op_b = s_data;
          state_nxt_s     = EXEC;
        end else begin
          state_nxt_s = GET_B;
        end
      end
      EXEC: begin
        m_data_nxt_s  = exec_resp_s.data;
        m_err_nxt_s   = exec_resp_s.err;
        m_valid_nxt_s = 1'b1;
        state_nxt_s   = RESP;
      end
      RESP: begin
        if (m_valid_r && m_ready) begin
          m_valid_nxt_s = 1'b0;
          op_cnt_nxt_s  = op_cnt_r + CNT_W'(1);
          state_nxt_s   = HDR;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        m_valid_nxt_s = 1'b0;
        state_nxt_s   = HDR;
      end
    endcase
  end

  assign s_ready = s_ready_s;
  assign INST    = inst_r;
  assign m_data  = m_data_r;
  assign m_err   = m_err_r;
  assign m_valid = m_valid_r;
  assign op_cnt  = op_cnt_r;

endmodule

// File: tb/tb_lab_ms_sv4_issuer.sv
// Bench for lab_ms_sv4_issuer together with a behavioural ALU; expected
// responses are queued when op_b is driven and checked on each handshake.
module tb_lab_ms_sv4_issuer;
  import lab_MS_SV4_pack::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  INST_t      inst;
  data_y      alu_out;
  data_y      m_data;
  logic       m_err;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] op_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_cnt;
  resp_t exp_q[$];

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] data;
    logic        err;
    int          gap;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  lab_ms_sv4_issuer #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .INST(inst), .ALU_out(alu_out), .m_data(m_data), .m_err(m_err),
    .m_valid(m_valid), .m_ready(m_ready), .op_cnt(op_cnt)
  );

  // Behavioural ALU; out-of-range results are deliberate junk the issuer must mask.
  function automatic data_y alu_f(input INST_t i);
    data_y a16, b16;
    a16 = {8'h00, i.op_a};
    b16 = {8'h00, i.op_b};
    case (i.opc)
      ADD:     return a16 + b16;
      SUB:     return a16 - b16;
      MUL:     return a16 * b16;
      DIV:     return (i.op_b == 8'h00) ? 16'hDEAD : a16 / b16;
      VAR:     return a16 * 16'd13 - b16;
      default: return 16'hBEEF;
    endcase
  endfunction
  assign alu_out = alu_f(inst);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_data", 32'(m_data), 32'(e.data));
        check("resp_err", 32'(m_err), 32'(e.err));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (!ok) check("byte_timeout", 32'd1, 32'd0);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [7:0] hdr, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] data, input logic err, input int gap);
    bit got;
    resp_t e;
    logic [18:0] exp_inst;
    exp_inst = {hdr[2:0], a, b};
    send_byte(hdr, gap);
    send_byte(a, gap);
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
    send_byte(b, 0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("resp_timeout", 32'd1, 32'd0);
    check("inst_held", 32'(inst), 32'(exp_inst));
    @(posedge clk);
    #1;
    exp_cnt = exp_cnt + 8'd1;
    check("op_cnt", 32'(op_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h02, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 0};
    vecs[1]  = '{8'h04, 8'h0A, 8'h05, 16'h007D, 1'b0, 0};
    vecs[2]  = '{8'h01, 8'h03, 8'h05, 16'hFFFE, 1'b0, 0};
    vecs[3]  = '{8'h03, 8'h07, 8'h00, 16'hFFFF, 1'b1, 0};
    vecs[4]  = '{8'h07, 8'h01, 8'h01, 16'h0000, 1'b1, 0};
    vecs[5]  = '{8'h03, 8'h64, 8'h07, 16'h000E, 1'b0, 0};
    vecs[6]  = '{8'h0D, 8'h02, 8'h02, 16'h0000, 1'b1, 0};
    vecs[7]  = '{8'h04, 8'h00, 8'h01, 16'hFFFF, 1'b0, 0};
    vecs[8]  = '{8'h00, 8'h10, 8'h20, 16'h0030, 1'b0, 0};
    vecs[9]  = '{8'hF8, 8'h10, 8'h20, 16'h0030, 1'b0, 2};
    vecs[10] = '{8'hFA, 8'h0C, 8'h0B, 16'h0084, 1'b0, 1};
    vecs[11] = '{8'h00, 8'hFF, 8'hFF, 16'h01FE, 1'b0, 0};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b1;
    exp_cnt = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    check("rst_inst", 32'(inst), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("hdr_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;

    // ADD with explicit latency: EXEC cycle first, then registered valid.
    begin
      resp_t e;
      send_byte(8'h00, 0);
      send_byte(8'h05, 0);
      e.data = 16'h0008;
      e.err  = 1'b0;
      exp_q.push_back(e);
      send_byte(8'h03, 0);
      @(negedge clk);
      check("lat_exec_valid", 32'(m_valid), 32'd0);
      check("lat_exec_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      check("lat_valid", 32'(m_valid), 32'd1);
      check("lat_data", 32'(m_data), 32'h0008);
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 8'd1;
      check("add_op_cnt", 32'(op_cnt), 32'(exp_cnt));
    end

    for (int v = 0; v < 12; v++)
      run_op(vecs[v].hdr, vecs[v].a, vecs[v].b, vecs[v].data, vecs[v].err, vecs[v].gap);

    // Backpressure: response held, no bytes taken, single count on release.
    begin
      resp_t e;
      bit got;
      m_ready = 1'b0;
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      e.data = 16'h0003;
      e.err  = 1'b0;
      exp_q.push_back(e);
      send_byte(8'h02, 0);
      s_data  = 8'h00;
      s_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (m_valid) begin
          got = 1'b1;
          break;
        end
      end
      check("bp_valid_seen", 32'(got), 32'd1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("bp_data", 32'(m_data), 32'h0003);
        check("bp_s_ready", 32'(s_ready), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
      end
      check("bp_cnt_hold", 32'(op_cnt), 32'(exp_cnt));
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 8'd1;
      check("bp_cnt_once", 32'(op_cnt), 32'(exp_cnt));
      @(negedge clk);
      check("bp_valid_drop", 32'(m_valid), 32'd0);
      check("bp_next_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("bp_cnt_stable", 32'(op_cnt), 32'(exp_cnt));
      send_byte(8'h02, 0);
      e.data = 16'h0005;
      exp_q.push_back(e);
      send_byte(8'h03, 0);
      @(negedge clk);
      @(negedge clk);
      check("bp_follow_valid", 32'(m_valid), 32'd1);
      @(posedge clk);
      #1;
      exp_cnt = exp_cnt + 8'd1;
      check("bp_follow_cnt", 32'(op_cnt), 32'(exp_cnt));
    end

    // Reset in the middle of a command.
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_data", 32'(m_data), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_err", 32'(m_err), 32'd0);
    check("mid_rst_op_cnt", 32'(op_cnt), 32'd0);
    check("mid_rst_inst", 32'(inst), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    exp_cnt = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(8'h00, 8'h01, 8'h01, 16'h0002, 1'b0, 0);

    for (int k = 0; k < 255; k++) begin
      logic [7:0] a8;
      a8 = 8'(k);
      run_op(8'h00, a8, 8'h01, 16'(k + 1), 1'b0, 0);
    end
    check("cnt_wrap", 32'(op_cnt), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
